// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared FSM state encoding and default vector constants for button_int_ctrl
package int_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_e;
  localparam logic [15:0] INT_VEC_BASE = 16'h0F80;
  localparam logic [15:0] INT_VEC_STRIDE = 16'h0020;
endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: combinational highest-index-wins priority encoder
module int_prio_enc #(
  parameter int N_CH = 4,
  parameter int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req,
  output logic            valid,
  output logic [ID_W-1:0] index
);
  // later (higher) channels overwrite earlier ones, so the top set bit wins
  always_comb begin
    valid = |req;
    index = '0;
    for (int i = 0; i < N_CH; i++) if (req[i]) index = ID_W'(i);
  end
endmodule

// File: rtl/button_int_ctrl.sv
// button_int_ctrl: edge-latched button interrupts with vectored request/service handshake (optional INT_SYNC_EN input synchronizer)
module button_int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int          N_CH       = 4,
  parameter int          PC_W       = 16,
  parameter logic [15:0] VEC_BASE   = INT_VEC_BASE,
  parameter logic [15:0] VEC_STRIDE = INT_VEC_STRIDE,
  localparam int         ID_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] irq_in,
  input  logic            mask_wr,
  input  logic [N_CH-1:0] mask_data,
  input  logic            int_ack,
  input  logic            ret,
  output logic            int_req,
  output logic [PC_W-1:0] int_vec,
  output logic [ID_W-1:0] int_id,
  output logic            int_active,
  output logic [N_CH-1:0] pending
);
  state_e          state_q;
  logic [N_CH-1:0] irq_s, hist_q, pend_q, pend_d, mask_q, rise, clr, elig;
  logic [ID_W-1:0] id_q, sel;
  logic [PC_W-1:0] vec_q;
  logic            sel_v;
`ifdef INT_SYNC_EN
  logic [N_CH-1:0] s1_q, s2_q;
  // two-flop synchronizer on the raw button levels
  always_ff @(posedge clk) begin
    if (rst) {s2_q, s1_q} <= '0;
    else {s2_q, s1_q} <= {s1_q, irq_in};
  end
  assign irq_s = s2_q;
`else
  assign irq_s = irq_in;
`endif
  assign rise   = irq_s & ~hist_q;
  assign elig   = pend_q & ~mask_q;
  assign clr    = (state_q == S_REQ && int_ack) ? N_CH'(1) << id_q : '0;
  assign pend_d = (pend_q & ~clr) | rise;
  int_prio_enc #(.N_CH(N_CH), .ID_W(ID_W)) u_enc (.req(elig), .valid(sel_v), .index(sel));
  // edge history, pending latch (new edge beats acknowledge clear) and mask register
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      hist_q <= irq_s;
      pend_q <= pend_d;
      if (mask_wr) mask_q <= mask_data;
    end
  end
  // request/service FSM; channel and vector are frozen when leaving IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      vec_q   <= PC_W'(VEC_BASE);
    end else begin
      case (state_q)
        S_IDLE: if (sel_v) begin
          state_q <= S_REQ;
          id_q    <= sel;
          vec_q   <= PC_W'(32'(VEC_BASE) + 32'(sel) * 32'(VEC_STRIDE));
        end
        S_REQ:     if (int_ack) state_q <= S_SERVICE;
        S_SERVICE: if (ret) state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end
  assign int_req    = state_q == S_REQ;
  assign int_active = state_q == S_SERVICE;
  assign int_id     = id_q;
  assign int_vec    = vec_q;
  assign pending    = pend_q;
endmodule
